pf_lanectrl_dly_seq: RTL and testbench

Parametrised delay-line training sequencer for NUM_LANES DDR PHY lane controllers. It accepts one tap-move or load request at a time and brackets it with a per-lane HS_IO_CLK_PAUSE window. It issues spaced single-cycle DELAY_LINE_MOVE pulses and stops early when the lane's synchronised out-of-range flag rises. It sits between the training fabric logic and the per-lane LANECTRL delay-line and pause inputs, and generalises the single-lane pause-sync function to multi-lane, multi-tap and pause-extension operation.

---
 rtl/pf_lanectrl_seq_pkg.sv | 28 ++
 rtl/pf_lanectrl_sync2.sv | 26 ++
 rtl/pf_lanectrl_dly_seq.sv | 200 ++++++++++++++++++++
 tb/tb_pf_lanectrl_dly_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pf_lanectrl_seq_pkg.sv
// Shared types for the lane-controller delay-line sequencer.
// State encoding, captured request record and the phase-counter width.
package pf_lanectrl_seq_pkg;

    localparam int PH_W       = 8;
    localparam int LANE_W_MAX = 8;
    localparam int TAP_W_MAX  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE_PRE,
        ST_MOVE,
        ST_LOAD,
        ST_SETTLE,
        ST_PAUSE_POST,
        ST_DONE
    } state_e;

    // Lane and taps are held at their widest supported size and narrowed by the top.
    typedef struct packed {
        logic [LANE_W_MAX-1:0] lane;
        logic                  load;
        logic                  sel;
        logic                  dir;
        logic [TAP_W_MAX-1:0]  taps;
    } req_t;

endpackage

// File: rtl/pf_lanectrl_sync2.sv
// Two-flop synchroniser for one asynchronous level, reset to 0.
// Latency: 2 clk_i cycles from a stable input to q_o.
// No backpressure: free-running.
module pf_lanectrl_sync2 (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pf_lanectrl_dly_seq.sv
// Multi-lane delay-line training sequencer: pause-bracketed tap moves or a default load.
// Latency: DONE at T+1+PAUSE_EXT+N*(1+MOVE_GAP)+SETTLE_CYCLES+PAUSE_EXT; T+1 for no-op/bad lane.
// Backpressure: one request in flight; REQ_READY high only in IDLE.
module pf_lanectrl_dly_seq
    import pf_lanectrl_seq_pkg::*;
#(
    parameter int  NUM_LANES     = 4,
    parameter int  TAP_W         = 8,
    parameter int  PAUSE_EXT     = 2,
    parameter int  MOVE_GAP      = 3,
    parameter int  SETTLE_CYCLES = 4,
    localparam int LW            = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 CLK,
    input  logic                 ARST_N,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [LW-1:0]        REQ_LANE,
    input  logic                 REQ_LOAD,
    input  logic                 REQ_SEL,
    input  logic                 REQ_DIR,
    input  logic [TAP_W-1:0]     REQ_TAPS,
    input  logic [NUM_LANES-1:0] RX_DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0] DELAY_LINE_SEL,
    output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
    output logic                 DONE,
    output logic [TAP_W-1:0]     DONE_TAPS,
    output logic                 ERR_OOR,
    output logic                 ERR_LANE
);

    localparam int OOR_EXT_W = 1 << LANE_W_MAX;

    state_e               state_q;
    logic [PH_W-1:0]      cnt_q;
    req_t                 req_q;
    logic [TAP_W-1:0]     moved_q;
    logic                 oor_hit_q;
    logic                 ready_q;
    logic                 done_q;
    logic [TAP_W-1:0]     done_taps_q;
    logic                 err_oor_q;
    logic                 err_lane_q;
    logic [NUM_LANES-1:0] pause_q;
    logic [NUM_LANES-1:0] move_q;
    logic [NUM_LANES-1:0] load_q;

    logic [NUM_LANES-1:0] oor_sync;
    logic [OOR_EXT_W-1:0] oor_ext;
    logic [NUM_LANES-1:0] req_oh;
    logic                 lane_bad;
    logic                 req_nop;
    logic                 taps_done;
    logic                 slot_oor;
    logic                 start_slot;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_sync
        pf_lanectrl_sync2 u_sync (
            .clk_i    (CLK),
            .arst_n_i (ARST_N),
            .d_i      (RX_DELAY_LINE_OUT_OF_RANGE[g]),
            .q_o      (oor_sync[g])
        );
    end

    assign oor_ext   = OOR_EXT_W'(oor_sync);
    assign req_oh    = NUM_LANES'(1) << REQ_LANE;
    assign lane_bad  = (int'(REQ_LANE) >= NUM_LANES);
    assign req_nop   = !REQ_LOAD && (REQ_TAPS == '0);
    assign taps_done = (TAP_W_MAX'(moved_q) == req_q.taps);
    assign slot_oor  = oor_ext[req_q.lane];

    // A slot opens on the edge that ends pre-pause or the previous gap; OOR is judged there.
    assign start_slot = (cnt_q == '0) &&
                        (((state_q == ST_PAUSE_PRE) && !req_q.load) ||
                         ((state_q == ST_MOVE) && !oor_hit_q && !taps_done));

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            moved_q     <= '0;
            oor_hit_q   <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            done_taps_q <= '0;
            err_oor_q   <= 1'b0;
            err_lane_q  <= 1'b0;
            pause_q     <= '0;
            move_q      <= '0;
            load_q      <= '0;
        end else begin
            done_q <= 1'b0;
            move_q <= '0;
            load_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        req_q <= '{lane: LANE_W_MAX'(REQ_LANE), load: REQ_LOAD, sel: REQ_SEL,
                                   dir: REQ_DIR, taps: TAP_W_MAX'(REQ_TAPS)};
                        ready_q   <= 1'b0;
                        moved_q   <= '0;
                        oor_hit_q <= 1'b0;
                        if (lane_bad || req_nop) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            done_taps_q <= '0;
                            err_oor_q   <= 1'b0;
                            err_lane_q  <= lane_bad;
                        end else begin
                            state_q <= ST_PAUSE_PRE;
                            cnt_q   <= PH_W'(PAUSE_EXT - 1);
                            pause_q <= req_oh;
                        end
                    end
                end
                ST_PAUSE_PRE: begin
                    if (cnt_q == '0) begin
                        if (req_q.load) begin
                            state_q <= ST_LOAD;
                            load_q  <= pause_q;
                        end else begin
                            state_q <= ST_MOVE;
                        end
                    end else begin
                        cnt_q <= cnt_q - PH_W'(1);
                    end
                end
                ST_MOVE: begin
                    if (oor_hit_q || ((cnt_q == '0) && taps_done)) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= PH_W'(SETTLE_CYCLES - 1);
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - PH_W'(1);
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_SETTLE;
                    cnt_q   <= PH_W'(SETTLE_CYCLES - 1);
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_PAUSE_POST;
                        cnt_q   <= PH_W'(PAUSE_EXT - 1);
                    end else begin
                        cnt_q <= cnt_q - PH_W'(1);
                    end
                end
                ST_PAUSE_POST: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_DONE;
                        pause_q     <= '0;
                        done_q      <= 1'b1;
                        done_taps_q <= moved_q;
                        err_oor_q   <= oor_hit_q;
                        err_lane_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - PH_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    pause_q <= '0;
                end
            endcase

            if (start_slot) begin
                cnt_q <= PH_W'(MOVE_GAP);
                if (slot_oor) begin
                    oor_hit_q <= 1'b1;
                end else begin
                    move_q  <= pause_q;
                    moved_q <= moved_q + TAP_W'(1);
                end
            end
        end
    end

    // pause_q is the one-hot active-lane mask for the whole window, so it gates SEL/DIR too.
    assign REQ_READY            = ready_q;
    assign HS_IO_CLK_PAUSE      = pause_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_SEL       = req_q.sel ? pause_q : '0;
    assign DELAY_LINE_DIRECTION = req_q.dir ? pause_q : '0;
    assign DONE                 = done_q;
    assign DONE_TAPS            = done_taps_q;
    assign ERR_OOR              = err_oor_q;
    assign ERR_LANE             = err_lane_q;

endmodule

// File: tb/tb_pf_lanectrl_dly_seq.sv
// Directed bench for pf_lanectrl_dly_seq with five lanes so that lanes 5..7 are out of range.
module tb_pf_lanectrl_dly_seq;

    localparam int NL = 5;
    localparam int TW = 8;
    localparam int PE = 2;
    localparam int MG = 3;
    localparam int SC = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [LW-1:0] req_lane = '0;
    logic          req_load = 1'b0;
    logic          req_sel = 1'b0;
    logic          req_dir = 1'b0;
    logic [TW-1:0] req_taps = '0;
    logic [NL-1:0] oor = '0;
    logic [NL-1:0] dl_move, dl_load, dl_sel, dl_dir, hs_pause;
    logic          done, err_oor, err_lane;
    logic [TW-1:0] done_taps;
    logic [26:0]   act;

    int n_pass = 0;
    int n_total = 0;
    int last_taps = 0;

    always #5 clk = ~clk;

    pf_lanectrl_dly_seq #(
        .NUM_LANES(NL), .TAP_W(TW), .PAUSE_EXT(PE), .MOVE_GAP(MG), .SETTLE_CYCLES(SC)
    ) dut (
        .CLK                        (clk),
        .ARST_N                     (arst_n),
        .REQ_VALID                  (req_valid),
        .REQ_READY                  (req_ready),
        .REQ_LANE                   (req_lane),
        .REQ_LOAD                   (req_load),
        .REQ_SEL                    (req_sel),
        .REQ_DIR                    (req_dir),
        .REQ_TAPS                   (req_taps),
        .RX_DELAY_LINE_OUT_OF_RANGE (oor),
        .DELAY_LINE_MOVE            (dl_move),
        .DELAY_LINE_LOAD            (dl_load),
        .DELAY_LINE_SEL             (dl_sel),
        .DELAY_LINE_DIRECTION       (dl_dir),
        .HS_IO_CLK_PAUSE            (hs_pause),
        .DONE                       (done),
        .DONE_TAPS                  (done_taps),
        .ERR_OOR                    (err_oor),
        .ERR_LANE                   (err_lane)
    );

    assign act = {hs_pause, dl_sel, dl_dir, dl_move, dl_load, done, req_ready};

    typedef struct {
        int lane;
        bit load;
        bit sel;
        bit dir;
        int taps;
        bit oor_pre;
        int oor_at;
        int exp_done;
        int exp_taps;
        bit exp_oor;
        bit exp_lerr;
        bit exp_pause;
    } vec_t;

    function automatic vec_t mk(input int lane, input bit load, input bit sel, input bit dir,
                                input int taps, input bit oor_pre, input int oor_at,
                                input int exp_done, input int exp_taps, input bit exp_oor,
                                input bit exp_lerr, input bit exp_pause);
        vec_t v;
        v.lane = lane; v.load = load; v.sel = sel; v.dir = dir; v.taps = taps;
        v.oor_pre = oor_pre; v.oor_at = oor_at; v.exp_done = exp_done;
        v.exp_taps = exp_taps; v.exp_oor = exp_oor; v.exp_lerr = exp_lerr;
        v.exp_pause = exp_pause;
        return v;
    endfunction

    // Expected lane/handshake outputs t cycles after the request is presented.
    function automatic logic [26:0] exp_bundle(input vec_t v, input int t);
        logic [NL-1:0] oh, p, s, d, m, l;
        oh = '0; p = '0; s = '0; d = '0; m = '0; l = '0;
        if (v.lane < NL) oh[v.lane] = 1'b1;
        if (v.exp_pause && t >= 1 && t <= v.exp_done - 1) begin
            p = oh;
            if (v.sel) s = oh;
            if (v.dir) d = oh;
        end
        if (v.exp_pause && !v.load && t >= PE + 1 && ((t - PE - 1) % (1 + MG)) == 0 &&
            ((t - PE - 1) / (1 + MG)) < v.exp_taps)
            m = oh;
        if (v.exp_pause && v.load && t == PE + 1) l = oh;
        return {p, s, d, m, l, (t == v.exp_done), (t == 0)};
    endfunction

    task automatic check(input string name, input int t, input logic [63:0] a, input logic [63:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s t=%0d actual=%h required=%h", name, t, a, e);
    endtask

    task automatic drive(input vec_t v, input bit vld);
        req_valid = vld;
        req_lane  = LW'(v.lane);
        req_load  = v.load;
        req_sel   = v.sel;
        req_dir   = v.dir;
        req_taps  = TW'(v.taps);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input bit chain, input vec_t nx);
        if (v.oor_pre && v.lane < NL) begin
            oor[v.lane] = 1'b1;
            repeat (3) step();
        end
        for (int t = 0; t <= v.exp_done; t++) begin
            if (t == 0 || !chain) drive(v, t == 0);
            else drive(nx, 1'b1);
            if (t == v.oor_at && v.lane < NL) oor[v.lane] = 1'b1;
            @(negedge clk);
            check("lanes", t, 64'(act), 64'(exp_bundle(v, t)));
            if (t == v.exp_done)
                check("done_info", t, 64'({done_taps, err_oor, err_lane}),
                      64'({TW'(v.exp_taps), v.exp_oor, v.exp_lerr}));
            step();
        end
        last_taps = v.exp_taps;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle", i, 64'(act), 64'(27'd1));
            if (i == 0) check("taps_held", i, 64'(done_taps), 64'(last_taps));
            step();
        end
    endtask

    vec_t tbl[9];
    vec_t va, vb;

    initial begin
        tbl[0] = mk(1, 0, 0, 1,   3, 0, -1,   21,   3, 0, 0, 1);
        tbl[1] = mk(2, 0, 1, 0,  10, 0, 16,   26,   4, 1, 0, 1);
        tbl[2] = mk(0, 1, 1, 1,   7, 0, -1,   10,   0, 0, 0, 1);
        tbl[3] = mk(5, 0, 0, 0,   3, 0, -1,    1,   0, 0, 1, 0);
        tbl[4] = mk(3, 0, 1, 1,   0, 0, -1,    1,   0, 0, 0, 0);
        tbl[5] = mk(4, 0, 1, 0,   1, 0, -1,   13,   1, 0, 0, 1);
        tbl[6] = mk(0, 0, 0, 1,   5, 1, -1,   10,   0, 1, 0, 1);
        tbl[7] = mk(1, 0, 0, 1, 255, 0, -1, 1029, 255, 0, 0, 1);
        tbl[8] = mk(7, 1, 1, 1,   0, 0, -1,    1,   0, 0, 1, 0);

        // Reset state while ARST_N is held low
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_lanes", 0, 64'(act), 64'(27'd1));
        check("reset_info", 0, 64'({done_taps, err_oor, err_lane}), 64'(0));
        step();
        arst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i], 1'b0, tbl[i]);
            oor = '0;
            idle(4);
        end

        // Request held valid with new fields while busy; second accepted right after DONE
        va = mk(1, 0, 0, 1, 1, 0, -1, 13, 1, 0, 0, 1);
        vb = mk(2, 0, 1, 0, 2, 0, -1, 17, 2, 0, 0, 1);
        run_vec(va, 1'b1, vb);
        run_vec(vb, 1'b0, vb);
        idle(3);

        // Reset in the middle of a 3-tap move
        for (int t = 0; t < 8; t++) begin
            drive(tbl[0], t == 0);
            @(negedge clk);
            check("pre_rst", t, 64'(act), 64'(exp_bundle(tbl[0], t)));
            step();
        end
        arst_n = 1'b0;
        #1;
        check("rst_drop", 8, 64'(act), 64'(27'd1));
        step();
        step();
        arst_n = 1'b1;
        last_taps = 0;
        idle(4);
        run_vec(tbl[0], 1'b0, tbl[0]);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
